// File: rtl/alu_issue_seq_if.sv
// Command and result handshake bundle for alu_issue_seq.
// master: command producer / result consumer; slave: the sequencer.
// cmd_chain is present only when ALU_ISSUE_SEQ_CHAIN_EN is defined.
interface alu_issue_seq_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_x;
   logic [3:0] cmd_y;
   logic [3:0] cmd_op;
`ifdef ALU_ISSUE_SEQ_CHAIN_EN
   logic       cmd_chain;
`endif
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_err;

`ifdef ALU_ISSUE_SEQ_CHAIN_EN
   modport master (output cmd_valid, cmd_x, cmd_y, cmd_op, cmd_chain, res_ready,
                   input  cmd_ready, res_valid, res_data, res_err);
   modport slave  (input  cmd_valid, cmd_x, cmd_y, cmd_op, cmd_chain, res_ready,
                   output cmd_ready, res_valid, res_data, res_err);
`else
   modport master (output cmd_valid, cmd_x, cmd_y, cmd_op, res_ready,
                   input  cmd_ready, res_valid, res_data, res_err);
   modport slave  (input  cmd_valid, cmd_x, cmd_y, cmd_op, res_ready,
                   output cmd_ready, res_valid, res_data, res_err);
`endif
endinterface

// File: rtl/alu_issue_seq.sv
// Issue/writeback sequencer for a 4-bit combinational ALU; optional operand chaining via ALU_ISSUE_SEQ_CHAIN_EN.
// Latency: accept edge -> operands loaded next edge -> result valid after the following edge (2 cycles).
// Backpressure: cmd_ready = !full; a held result (res_ready low) stalls issue, FIFO keeps filling.
module alu_issue_seq #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   alu_issue_seq_if.slave       bus,
   output logic [3:0]           alu_x,
   output logic [3:0]           alu_y,
   output logic [3:0]           alu_op,
   input  logic [3:0]           alu_o,
   input  logic [7:0]           alu_product,
   output logic                 busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   typedef struct packed {
`ifdef ALU_ISSUE_SEQ_CHAIN_EN
      logic       chain;
`endif
      logic [3:0] op;
      logic [3:0] y;
      logic [3:0] x;
   } cmd_t;

   cmd_t            mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   state_t          state_q;
   logic [3:0]      alu_x_q, alu_y_q, alu_op_q;
   logic [7:0]      res_data_q;
   logic            res_err_q, res_valid_q;

   cmd_t            wr_cmd, head;
   logic            fifo_full, fifo_nempty, push, pop;
   logic [3:0]      load_x;
   logic [7:0]      cap_data;
   logic            cap_err;

   assign fifo_full   = (count_q == CW'(DEPTH));
   assign fifo_nempty = (count_q != '0);
   assign push        = bus.cmd_valid && !fifo_full;
   // A head is consumed when idle, or when the held result is handed off.
   assign pop         = fifo_nempty &&
                        ((state_q == IDLE) || ((state_q == DONE) && bus.res_ready));
   assign head        = mem_q[rd_ptr_q];

   assign bus.cmd_ready = !fifo_full;
   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_err   = res_err_q;
   assign alu_x         = alu_x_q;
   assign alu_y         = alu_y_q;
   assign alu_op        = alu_op_q;
   assign busy          = (state_q != IDLE) || fifo_nempty;

   // Pack the incoming command into a FIFO entry and pick the x operand at load.
   always_comb begin
      wr_cmd.op = bus.cmd_op;
      wr_cmd.y  = bus.cmd_y;
      wr_cmd.x  = bus.cmd_x;
`ifdef ALU_ISSUE_SEQ_CHAIN_EN
      wr_cmd.chain = bus.cmd_chain;
      // res_data_q always holds the most recent capture (0 after reset).
      load_x = head.chain ? res_data_q[3:0] : head.x;
`else
      load_x = head.x;
`endif
   end

   // Select the result width and error flag from the opcode in flight.
   always_comb begin
      cap_data = {4'b0000, alu_o};
      cap_err  = 1'b0;
      case (alu_op_q)
         4'b1010: cap_data = alu_product;
         4'b1011: begin
            if (alu_y_q == 4'd0) begin
               cap_data = 8'hFF;
               cap_err  = 1'b1;
            end else begin
               cap_data = alu_product;
            end
         end
         4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
            cap_data = 8'h00;
            cap_err  = 1'b1;
         end
         default: ;
      endcase
   end

   // Command storage; entries beyond the pointers are don't-care, so no reset.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_cmd;
   end

   // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end

   // Sequencer FSM with registered ALU operands and result outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         alu_x_q     <= '0;
         alu_y_q     <= '0;
         alu_op_q    <= '0;
         res_data_q  <= '0;
         res_err_q   <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         if (pop) begin
            alu_x_q  <= load_x;
            alu_y_q  <= head.y;
            alu_op_q <= head.op;
         end
         case (state_q)
            IDLE: begin
               if (fifo_nempty) state_q <= EXEC;
            end
            EXEC: begin
               res_data_q  <= cap_data;
               res_err_q   <= cap_err;
               res_valid_q <= 1'b1;
               state_q     <= DONE;
            end
            DONE: begin
               if (bus.res_ready) begin
                  res_valid_q <= 1'b0;
                  state_q     <= fifo_nempty ? EXEC : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq with a behavioural 4-bit ALU.
// Vector table covers single-command results; hand sequences cover reset, fill and chaining.
module tb_alu_issue_seq;
   localparam int DEPTH = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] alu_x, alu_y, alu_op, alu_o;
   logic [7:0] alu_product;
   logic       busy;
   logic       last_chain;

   int n_checks = 0;
   int n_fail   = 0;

   alu_issue_seq_if bus ();

   alu_issue_seq #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .alu_x       (alu_x),
      .alu_y       (alu_y),
      .alu_op      (alu_op),
      .alu_o       (alu_o),
      .alu_product (alu_product),
      .busy        (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural ALU; unused result paths carry marker values.
   always_comb begin
      alu_o       = 4'h3;
      alu_product = 8'h5A;
      case (alu_op)
         4'h0: alu_o = alu_x & alu_y;
         4'h1: alu_o = alu_x | alu_y;
         4'h2: alu_o = alu_x ^ alu_y;
         4'h3: alu_o = ~alu_x;
         4'h4: alu_o = alu_x - alu_y;
         4'h5: alu_o = alu_x << 1;
         4'h6: alu_o = alu_x >> 1;
         4'h7: alu_o = alu_y;
         4'h8: alu_o = alu_x + alu_y;
         4'h9: alu_o = alu_x;
         4'hA: alu_product = {4'b0, alu_x} * {4'b0, alu_y};
         4'hB: alu_product = (alu_y == 4'd0) ? 8'hAA : {alu_x % alu_y, alu_x / alu_y};
         default: begin
            alu_o       = 4'hF;
            alu_product = 8'hEE;
         end
      endcase
   end

   typedef struct {
      logic [3:0] op;
      logic [3:0] x;
      logic [3:0] y;
      logic [7:0] data;
      logic       err;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] op, input logic [3:0] x, input logic [3:0] y,
                        input logic ch);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_x     = x;
      bus.cmd_y     = y;
      last_chain    = ch;
`ifdef ALU_ISSUE_SEQ_CHAIN_EN
      bus.cmd_chain = ch;
`endif
   endtask

   task automatic wait_res(input int budget, output int cyc);
      cyc = 0;
      while (!bus.res_valid && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   // One command from idle with res_ready high: checks load timing and capture.
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      chk("vec_ready", bus.cmd_ready, 1'b1);
      drive(v.op, v.x, v.y, 1'b0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("vec_busy", busy, 1'b1);
      @(negedge clk);
      chk("vec_alu_op", alu_op, v.op);
      chk("vec_alu_xy", {alu_x, alu_y}, {v.x, v.y});
      chk("vec_early_valid", bus.res_valid, 1'b0);
      @(negedge clk);
      chk("vec_valid", bus.res_valid, 1'b1);
      chk("vec_data", bus.res_data, v.data);
      chk("vec_err", bus.res_err, v.err);
      @(negedge clk);
      chk("vec_handoff", {bus.res_valid, busy}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc, idx, last;
      logic [7:0] exp_q [$];

      vecs[0]  = '{4'h8, 4'h5, 4'h3, 8'h08, 1'b0};
      vecs[1]  = '{4'hA, 4'h6, 4'h7, 8'h2A, 1'b0};
      vecs[2]  = '{4'hB, 4'h9, 4'h0, 8'hFF, 1'b1};
      vecs[3]  = '{4'hD, 4'h1, 4'h2, 8'h00, 1'b1};
      vecs[4]  = '{4'h0, 4'hC, 4'hA, 8'h08, 1'b0};
      vecs[5]  = '{4'h2, 4'hC, 4'hA, 8'h06, 1'b0};
      vecs[6]  = '{4'hB, 4'hD, 4'h4, 8'h13, 1'b0};
      vecs[7]  = '{4'hA, 4'hF, 4'hF, 8'hE1, 1'b0};
      vecs[8]  = '{4'hF, 4'h3, 4'h3, 8'h00, 1'b1};
      vecs[9]  = '{4'h8, 4'hF, 4'h1, 8'h00, 1'b0};
      vecs[10] = '{4'h9, 4'h7, 4'h0, 8'h07, 1'b0};
      vecs[11] = '{4'h4, 4'h3, 4'h5, 8'h0E, 1'b0};

      rst_n         = 1'b0;
      bus.res_ready = 1'b1;
      last_chain    = 1'b0;
      drive(4'h0, 4'h0, 4'h0, 1'b0);
      bus.cmd_valid = 1'b0;
      #2;
      chk("rst_outputs", {bus.res_valid, bus.res_err, busy, bus.cmd_ready}, 4'b0001);
      chk("rst_regs", {alu_x, alu_y, alu_op, bus.res_data}, 20'h0);
      #10 rst_n = 1'b1;

      // Single commands from the vector table.
      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Asynchronous reset while a result is held in DONE.
      @(negedge clk);
      bus.res_ready = 1'b0;
      drive(4'h8, 4'h2, 4'h2, 1'b0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      wait_res(10, cyc);
      chk("hold_valid", bus.res_valid, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("hold_stable", {bus.res_valid, bus.res_data}, {1'b1, 8'h04});
      #2 rst_n = 1'b0;
      #1;
      chk("arst_outputs", {bus.res_valid, busy, bus.cmd_ready}, 3'b001);
      chk("arst_regs", {alu_op, bus.res_data}, 12'h0);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("arst_discard", {bus.res_valid, busy}, 2'b00);

      // Fill FIFO plus the DONE slot while the consumer stalls.
      for (int i = 0; i <= DEPTH; i++) begin
         @(negedge clk);
         chk("fill_ready", bus.cmd_ready, 1'b1);
         drive(4'h8, 4'(i), 4'h1, 1'b0);
         exp_q.push_back(8'(i + 1));
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         drive(4'h8, 4'h9, 4'h9, 1'b0);
         chk("full_ready", bus.cmd_ready, 1'b0);
         chk("full_held", {bus.res_valid, bus.res_data}, {1'b1, 8'h01});
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      idx  = 0;
      last = 0;
      for (int c = 0; c < 40 && idx <= DEPTH; c++) begin
         if (bus.res_valid) begin
            chk("drain_data", bus.res_data, exp_q[idx]);
            if (idx > 0) chk("drain_spacing", c - last, 2);
            last = c;
            idx++;
         end
         @(negedge clk);
      end
      chk("drain_count", idx, DEPTH + 1);
      @(negedge clk);
      chk("drain_idle", {busy, bus.res_valid, bus.cmd_ready}, 3'b001);

`ifdef ALU_ISSUE_SEQ_CHAIN_EN
      // Back-to-back chaining: second x comes from the first result.
      @(negedge clk);
      drive(4'h8, 4'h1, 4'h2, 1'b0);
      @(negedge clk);
      drive(4'h8, 4'hF, 4'h4, 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      exp_q.delete();
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h07);
      idx = 0;
      for (int c = 0; c < 20 && idx < 2; c++) begin
         if (bus.res_valid) begin
            chk("chain_data", bus.res_data, exp_q[idx]);
            idx++;
         end
         @(negedge clk);
      end
      chk("chain_count", idx, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
